insn_encoder: RTL and testbench

INSN_ENCODER -- requirements
Module: insn_encoder

---
 rtl/insn_encoder_if.sv | 34 +++
 rtl/insn_encoder.sv | 157 +++++++++++++++
 tb/tb_insn_encoder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/insn_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
// The producer/imem side uses master; the encoder uses slave.
interface insn_encoder_if #(
  parameter int AW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_fmt;
  logic [4:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_shamt;
  logic [4:0]    in_aluop;
  logic [31:0]   in_imm;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop,
           in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop,
           in_imm, in_last, out_ready,
    output in_ready, out_valid, out_word, out_addr, out_err
  );
endinterface

// File: rtl/insn_encoder.sv
// Packs R/I/JI instruction fields into 32-bit words behind a one-deep output
// register, tagging each with its imem address and an overflow/illegal flag.
module insn_encoder #(
  parameter int AW = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  insn_encoder_if.slave    bus,
  output logic [7:0]       err_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [31:0]   word_q,  word_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic          err_q,   err_d;
  logic          last_q,  last_d;
  logic [7:0]    cnt_q,   cnt_d;
  logic          in_ready_s;
  logic          accept_s;
  logic          hs_s;
  logic          start_clr_s;
  logic [32:0]   enc_s;

  // Returns {err, word}; narrowing is a signed-range check on the dropped bits.
  function automatic logic [32:0] encode_insn(
    input logic [1:0]  fmt,
    input logic [4:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  sh,
    input logic [4:0]  al,
    input logic [31:0] imm
  );
    logic [31:0] word;
    logic        err;
    word = 32'h0000_0000;
    err  = 1'b0;
    case (fmt)
      2'd0: begin
        word = {op, rd, rs, rt, sh, al, 2'b00};
        err  = 1'b0;
      end
      2'd1: begin
        word = {op, rd, rs, imm[16:0]};
        err  = (imm[31:17] != {15{imm[16]}});
      end
      2'd2: begin
        word = {op, imm[26:0]};
        err  = (imm[31:27] != {5{imm[26]}});
      end
      default: begin
        word = 32'h0000_0000;
        err  = 1'b1;
      end
    endcase
    return {err, word};
  endfunction

  // Handshakes, next state and next output-stage contents.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    word_d      = word_q;
    addr_d      = addr_q;
    err_d       = err_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    hs_s        = valid_q && bus.out_ready;
    in_ready_s  = (state_q == ST_LOAD) && (!valid_q || bus.out_ready);
    accept_s    = bus.in_valid && in_ready_s;
    start_clr_s = start && (state_q != ST_LOAD);
    enc_s       = encode_insn(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs,
                              bus.in_rt, bus.in_shamt, bus.in_aluop, bus.in_imm);

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
        else       state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (hs_s && last_q) state_d = ST_DONE;
        else                state_d = ST_LOAD;
      end
      ST_DONE: begin
        if (start) state_d = ST_LOAD;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_s) begin
      valid_d = 1'b1;
      word_d  = enc_s[31:0];
      err_d   = enc_s[32];
      last_d  = bus.in_last;
    end else if (hs_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // A start outside LOAD wins over a coincident handshake.
    if (start_clr_s) begin
      addr_d = {AW{1'b0}};
      cnt_d  = 8'h00;
    end else if (hs_s) begin
      addr_d = addr_q + AW'(1'b1);
      if (err_q && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'h01;
      else                           cnt_d = cnt_q;
    end else begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
    end
  end

  // State and output-stage registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      word_q  <= 32'h0000_0000;
      addr_q  <= {AW{1'b0}};
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_err   = err_q;
  assign err_count     = cnt_q;
  assign busy          = (state_q == ST_LOAD);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_insn_encoder.sv
// Randomized scoreboard bench for insn_encoder: a driver pushes reference-model
// results at acceptance and a monitor pops and compares on each output handshake.
module tb_insn_encoder;
  localparam int AW = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] err_count;
  logic       busy;
  logic       done;

  insn_encoder_if #(.AW(AW)) bus();

  insn_encoder #(.AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .err_count (err_count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]   word;
    logic [AW-1:0] addr;
    logic          err;
    logic [7:0]    cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   widx  = 0;
  int   nerr  = 0;
  bit   ready_rand  = 1'b0;
  bit   ready_force = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: fields placed by weight, overflow judged on the signed immediate value.
  function automatic void ref_model(input int fmt, input logic [4:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] sh, input logic [4:0] al,
                                    input logic [31:0] imm,
                                    output logic [31:0] w, output logic e);
    longint s;
    longint u;
    longint v;
    s = longint'($signed(imm));
    u = longint'(imm);
    v = 0;
    e = 1'b0;
    case (fmt)
      0: v = longint'(op) * 134217728 + longint'(rd) * 4194304 + longint'(rs) * 131072
           + longint'(rt) * 4096 + longint'(sh) * 128 + longint'(al) * 4;
      1: begin
        v = longint'(op) * 134217728 + longint'(rd) * 4194304 + longint'(rs) * 131072
          + (u % 131072);
        e = (s < -65536) || (s > 65535);
      end
      2: begin
        v = longint'(op) * 134217728 + (u % 134217728);
        e = (s < -67108864) || (s > 67108863);
      end
      default: begin
        v = 0;
        e = 1'b1;
      end
    endcase
    w = 32'(v);
  endfunction

  task automatic send(input int fmt, input logic [4:0] op, input logic [4:0] rd,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh,
                      input logic [4:0] al, input logic [31:0] imm, input bit last);
    exp_t        x;
    logic [31:0] w;
    logic        e;
    ref_model(fmt, op, rd, rs, rt, sh, al, imm, w, e);
    bus.in_fmt    = 2'(fmt);
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_shamt  = sh;
    bus.in_aluop  = al;
    bus.in_imm    = imm;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        x.word = w;
        x.err  = e;
        x.addr = AW'(widx);
        x.cnt  = (nerr > 255) ? 8'd255 : 8'(nerr);
        sb.push_back(x);
        widx++;
        if (e) nerr++;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_mis++;
    $display("FAIL accept_timeout: in_ready never rose, expected acceptance");
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit last);
    logic [31:0] bnd [8];
    logic [31:0] imm;
    bnd = '{32'h0000FFFF, 32'h00010000, 32'hFFFF0000, 32'hFFFEFFFF,
            32'h03FFFFFF, 32'h04000000, 32'hFC000000, 32'hFBFFFFFF};
    case ($urandom_range(0, 2))
      0:       imm = $urandom;
      1:       imm = 32'($signed(16'($urandom)));
      default: imm = bnd[$urandom_range(0, 7)];
    endcase
    send($urandom_range(0, 3), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), 5'($urandom), imm, last);
  endtask

  task automatic pulse_start(input bit clear_model);
    start = 1'b1;
    if (clear_model) begin
      widx = 0;
      nerr = 0;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(negedge clock);
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_word"},  bus.out_word,  32'h0);
    chk({tag, "_out_addr"},  bus.out_addr,  {AW{1'b0}});
    chk({tag, "_out_err"},   bus.out_err,   1'b0);
    chk({tag, "_err_count"}, err_count,     8'd0);
    chk({tag, "_busy"},      busy,          1'b0);
    chk({tag, "_done"},      done,          1'b0);
    chk({tag, "_in_ready"},  bus.in_ready,  1'b0);
  endtask

  // Backpressure source: random or forced, updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: every output handshake consumes one scoreboard entry.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      if (reset && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_word: got 0x%0h with empty scoreboard, expected none",
                   bus.out_word);
        end else begin
          x = sb.pop_front();
          chk("out_word",  bus.out_word, x.word);
          chk("out_addr",  bus.out_addr, x.addr);
          chk("out_err",   bus.out_err,  x.err);
          chk("err_count", err_count,    x.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_fmt = 2'd0; bus.in_opcode = 5'd0; bus.in_rd = 5'd0; bus.in_rs = 5'd0;
    bus.in_rt = 5'd0; bus.in_shamt = 5'd0; bus.in_aluop = 5'd0;
    bus.in_imm = 32'h0; bus.in_last = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_state("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Directed encodings and overflow boundaries.
    pulse_start(1'b1);
    @(negedge clock);
    chk("busy_after_start", busy, 1'b1);
    @(posedge clock);
    #1;
    send(1, 5'd5, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    send(1, 5'd3, 5'd4, 5'd6, 5'd0, 5'd0, 5'd0, 32'h00010000, 1'b0);
    send(2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h03FFFFFF, 1'b0);
    send(2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h04000000, 1'b0);
    send(0, 5'd31, 5'd17, 5'd9, 5'd3, 5'd30, 5'd21, 32'h80000000, 1'b0);
    send(3, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 32'h0, 1'b0);
    drain();
    chk("err_count_directed", err_count, 8'd3);

    // Backpressure: word held for three cycles, then one handshake.
    ready_rand = 1'b0;
    ready_force = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    send(0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_out_valid", bus.out_valid, 1'b1);
      chk("stall_in_ready",  bus.in_ready,  1'b0);
      chk("stall_word",      bus.out_word,  sb[0].word);
      chk("stall_addr",      bus.out_addr,  sb[0].addr);
      chk("stall_err",       bus.out_err,   sb[0].err);
    end
    ready_force = 1'b1;
    drain();
    @(negedge clock);
    chk("release_addr",  bus.out_addr,  AW'(widx));
    chk("release_valid", bus.out_valid, 1'b0);

    // Random traffic with address wrap; a start inside LOAD must be ignored.
    ready_rand = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) pulse_start(1'b0);
      send_rand(1'b0);
    end
    send_rand(1'b0);
    send_rand(1'b0);
    send_rand(1'b1);
    drain();
    @(negedge clock);
    chk("done_after_last", done, 1'b1);
    chk("busy_after_last", busy, 1'b0);
    chk("in_ready_done",   bus.in_ready, 1'b0);
    @(posedge clock);
    #1;
    pulse_start(1'b1);
    @(negedge clock);
    chk("restart_busy",      busy, 1'b1);
    chk("restart_done",      done, 1'b0);
    chk("restart_addr",      bus.out_addr, {AW{1'b0}});
    chk("restart_err_count", err_count, 8'd0);
    @(posedge clock);
    #1;

    // Error-count saturation, then cleared by the next start.
    for (int i = 0; i < 262; i++) send(3, 5'($urandom), 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, $urandom, 1'b0);
    send_rand(1'b1);
    drain();
    @(negedge clock);
    chk("err_count_sat", err_count, 8'd255);
    @(posedge clock);
    #1;
    pulse_start(1'b1);
    @(negedge clock);
    chk("err_count_clear", err_count, 8'd0);

    // Reset while a word is pending discards it.
    ready_rand = 1'b0;
    ready_force = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    send(1, 5'd9, 5'd8, 5'd7, 5'd0, 5'd0, 5'd0, 32'h00001234, 1'b0);
    @(negedge clock);
    chk("pending_valid", bus.out_valid, 1'b1);
    reset = 1'b0;
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    chk_reset_state("midload_reset");
    reset = 1'b1;
    ready_force = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_after_reset_valid", bus.out_valid, 1'b0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
